rotate_point: RTL and testbench

Two-dimensional fixed-point rotator that consumes the sine/cosine amplitudes produced by the trig stage and applies them to a point. It accepts a signed point and an angle in degrees, presents the reduced angle to the external sine and cosine units, and waits a fixed latency for their results. It then computes x' = x·cos − y·sin and y' = x·sin + y·cos, and delivers the rotated point through a valid/ready handshake to the downstream projection logic.

---
 rtl/rotate_point.sv | 210 +++++++++++++++++++++
 tb/tb_rotate_point.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_point.sv
// rotate_point
//   Rotates a signed 16-bit point by an angle in degrees. The angle is
//   reduced to 0..359 and presented to the external sine/cosine units. After
//   TRIG_LATENCY cycles their Q16.16 results are captured. The rotated point
//   is computed as:
//     x' = x*cos - y*sin
//     y' = x*sin + y*cos
//   The result uses round-half-up and is delivered over a valid/ready
//   handshake.
//
//   Ports
//     clk_in          system clock
//     rst_in          synchronous active-high reset
//     valid_in        request strobe (x_in, y_in, angle_in valid)
//     ready_out       high in IDLE only; request accepted on valid_in&&ready_out
//     x_in, y_in      signed 16-bit point
//     angle_in        angle in degrees, 0..511
//     trig_angle_out  reduced angle (0..359) to the sine/cosine units
//     sin_in, cos_in  signed Q16.16 trig results
//     x_out, y_out    signed 16-bit rotated point
//     valid_out       result valid, held until ready_in
//     ready_in        downstream accepts the result
//
//   Build option
//     ROTATE_SATURATE_EN  when defined, results clamp to the 16-bit range;
//                         otherwise they wrap (low 16 bits kept).

module rotate_point #(
  parameter int TRIG_LATENCY = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  input  logic        [8:0]  angle_in,
  output logic        [8:0]  trig_angle_out,
  input  logic signed [31:0] sin_in,
  input  logic signed [31:0] cos_in,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out,
  output logic               valid_out,
  input  logic               ready_in
);

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 32;
  localparam int PROD_W  = DATA_W + COEF_W;   // 48
  localparam int SUM_W   = PROD_W + 1;        // 49
  localparam int SHIFT_W = SUM_W - 16;        // 33

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MUL,
    S_SUM,
    S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic        [3:0]         cnt_q, cnt_d;
  logic        [8:0]         trig_q, trig_d;
  logic signed [DATA_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [COEF_W-1:0]  sin_q, sin_d, cos_q, cos_d;
  logic signed [PROD_W-1:0]  xc_q, xc_d, ys_q, ys_d, xs_q, xs_d, yc_q, yc_d;
  logic signed [DATA_W-1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic                      valid_out_q, valid_out_d;

  logic signed [SUM_W-1:0]   px, py;

  // Round half up: add one half LSB of the Q16.16 result, then drop the
  // 16 fraction bits arithmetically.
  function automatic logic signed [SHIFT_W-1:0] round_shift(
    input logic signed [SUM_W-1:0] v
  );
    logic signed [SUM_W-1:0] r;
    r = v + SUM_W'(32768);
    return $signed(r[SUM_W-1:16]);
  endfunction

  function automatic logic signed [DATA_W-1:0] reduce16(
    input logic signed [SHIFT_W-1:0] v
  );
`ifdef ROTATE_SATURATE_EN
    localparam logic signed [SHIFT_W-1:0] MAX_V = SHIFT_W'(32767);
    localparam logic signed [SHIFT_W-1:0] MIN_V = -SHIFT_W'(32768);
    if (v > MAX_V) begin
      return 16'sh7fff;
    end else if (v < MIN_V) begin
      return -16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Sums of the registered products. Their range of about 2^47 fits
  // 49 bits with margin for the rounding add.
  assign px = SUM_W'(xc_q) - SUM_W'(ys_q);
  assign py = SUM_W'(xs_q) + SUM_W'(yc_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trig_d      = trig_q;
    x_d         = x_q;
    y_d         = y_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    xc_d        = xc_q;
    ys_d        = ys_q;
    xs_d        = xs_q;
    yc_d        = yc_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    valid_out_d = valid_out_q;

    unique case (state_q)
      // Accept: capture the point and reduce the angle into 0..359.
      S_IDLE: begin
        if (valid_in) begin
          x_d     = x_in;
          y_d     = y_in;
          trig_d  = (angle_in >= 9'd360) ? angle_in - 9'd360 : angle_in;
          cnt_d   = 4'(TRIG_LATENCY);
          state_d = S_WAIT;
        end
      end
      // Trig wait: sample sin/cos on the TRIG_LATENCY-th edge after accept.
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          sin_d   = sin_in;
          cos_d   = cos_in;
          state_d = S_MUL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Multiply stage.
      S_MUL: begin
        xc_d    = PROD_W'(x_q) * PROD_W'(cos_q);
        ys_d    = PROD_W'(y_q) * PROD_W'(sin_q);
        xs_d    = PROD_W'(x_q) * PROD_W'(sin_q);
        yc_d    = PROD_W'(y_q) * PROD_W'(cos_q);
        state_d = S_SUM;
      end
      // Sum, round and reduce stage.
      S_SUM: begin
        x_out_d     = reduce16(round_shift(px));
        y_out_d     = reduce16(round_shift(py));
        valid_out_d = 1'b1;
        state_d     = S_OUT;
      end
      // Output hold until the downstream takes the result.
      S_OUT: begin
        if (ready_in) begin
          valid_out_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      trig_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      xc_q        <= '0;
      ys_q        <= '0;
      xs_q        <= '0;
      yc_q        <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_q      <= trig_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      xc_q        <= xc_d;
      ys_q        <= ys_d;
      xs_q        <= xs_d;
      yc_q        <= yc_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign ready_out      = (state_q == S_IDLE);
  assign trig_angle_out = trig_q;
  assign x_out          = x_out_q;
  assign y_out          = y_out_q;
  assign valid_out      = valid_out_q;

endmodule

// File: tb/tb_rotate_point.sv
// tb_rotate_point
//   Directed bench for rotate_point with TRIG_LATENCY = 3.
//   The external trig units are modelled as a lookup on trig_angle_out
//   delayed by two registers. The looked-up value is therefore present on
//   sin_in/cos_in exactly at the third edge after the angle changes.
//   Define ROTATE_SATURATE_EN for both the bench and the RTL to select the
//   clamping expectation.

module tb_rotate_point;

  logic               clk_in;
  logic               rst_in;
  logic               valid_in;
  logic               ready_out;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic        [8:0]  angle_in;
  logic        [8:0]  trig_angle_out;
  logic signed [31:0] sin_in;
  logic signed [31:0] cos_in;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic               valid_out;
  logic               ready_in;

  int n_cmp = 0;
  int n_err = 0;

  rotate_point #(.TRIG_LATENCY(3)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .x_in           (x_in),
    .y_in           (y_in),
    .angle_in       (angle_in),
    .trig_angle_out (trig_angle_out),
    .sin_in         (sin_in),
    .cos_in         (cos_in),
    .x_out          (x_out),
    .y_out          (y_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Trig unit model: two pipeline registers, then a lookup.
  logic [8:0] ang_p1, ang_p2;
  always_ff @(posedge clk_in) begin
    ang_p1 <= trig_angle_out;
    ang_p2 <= ang_p1;
  end

  always_comb begin
    sin_in = 32'sh0000_0000;
    cos_in = 32'sh0001_0000;
    case (ang_p2)
      9'd90: begin
        sin_in = 32'sh0001_0000;
        cos_in = 32'sh0000_0000;
      end
      9'd180: begin
        sin_in = 32'sh0000_0000;
        cos_in = 32'shFFFF_0000;
      end
      9'd45: begin
        sin_in = 32'sh0000_B505;
        cos_in = 32'sh0000_B505;
      end
      default: begin
        sin_in = 32'sh0000_0000;
        cos_in = 32'sh0001_0000;
      end
    endcase
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One full request: accept, wait for the result, optional backpressure,
  // then handshake.
  task automatic do_req(input logic signed [15:0] xv, input logic signed [15:0] yv,
                        input logic [8:0] ang, input int exp_trig,
                        input int exp_x, input int exp_y, input int hold);
    int lat;
    bit seen;
    @(negedge clk_in);
    x_in     = xv;
    y_in     = yv;
    angle_in = ang;
    valid_in = 1'b1;
    check_eq("ready_idle", ready_out, 1);
    @(negedge clk_in);
    valid_in = 1'b0;
    check_eq("trig_angle", trig_angle_out, exp_trig);
    check_eq("busy_after_accept", ready_out, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk_in);
      lat++;
      seen = valid_out;
      if (!seen) check_eq("trig_hold", trig_angle_out, exp_trig);
    end
    check_eq("latency", lat, 5);
    check_eq("x_out", x_out, exp_x);
    check_eq("y_out", y_out, exp_y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      check_eq("bp_valid", valid_out, 1);
      check_eq("bp_x", x_out, exp_x);
      check_eq("bp_y", y_out, exp_y);
      check_eq("bp_ready", ready_out, 0);
    end
    ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    check_eq("valid_clear", valid_out, 0);
    check_eq("ready_back", ready_out, 1);
    check_eq("x_retained", x_out, exp_x);
  endtask

  initial begin
    int vcount;
    int exp_y45;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    x_in     = '0;
    y_in     = '0;
    angle_in = '0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    check_eq("rst_ready", ready_out, 1);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_x", x_out, 0);
    check_eq("rst_y", y_out, 0);
    check_eq("rst_trig", trig_angle_out, 0);

    do_req(16'sd100, 16'sd50, 9'd0,   0,   100,  50,  0);
    do_req(16'sd100, 16'sd50, 9'd90,  90,  -50,  100, 0);
    do_req(16'sd100, 16'sd50, 9'd180, 180, -100, -50, 0);
    do_req(16'sd100, 16'sd50, 9'd400, 40,  100,  50,  0);
    do_req(16'sd100, 16'sd50, 9'd359, 359, 100,  50,  0);
    do_req(16'sd100, 16'sd50, 9'd360, 0,   100,  50,  0);
`ifdef ROTATE_SATURATE_EN
    exp_y45 = 32767;
`else
    exp_y45 = -19196;
`endif
    do_req(16'sd32767, 16'sd32767, 9'd45, 45, 0, exp_y45, 0);
    do_req(16'sd100, 16'sd50, 9'd90, 90, -50, 100, 10);

    // Abort a request while it waits for the trig units.
    @(negedge clk_in);
    x_in     = 16'sd100;
    y_in     = 16'sd50;
    angle_in = 9'd90;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_eq("abort_ready", ready_out, 1);
    check_eq("abort_valid", valid_out, 0);
    check_eq("abort_trig", trig_angle_out, 0);
    check_eq("abort_x", x_out, 0);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (valid_out) vcount++;
    end
    check_eq("abort_no_result", vcount, 0);
    do_req(16'sd100, 16'sd50, 9'd180, 180, -100, -50, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
